// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control stage of the 5-stage miniRV pipeline. It sits directly
// downstream of the RAW detector. It turns the per-stage hazard flags and the
// EXE branch-taken signal into PC hold, IF/ID hold/flush and ID/EXE bubble
// controls. It also owns the last-write-back PC register that feeds back into
// the detector. A small FSM tracks how long a stall run lasts. A sticky
// watchdog flag rises when a run is longer than MAX_STALL. Two saturating
// counters record stalled cycles and flush events.
//
// Control handshake: none of the outputs has a valid/ready pair. They are
// level signals that apply to the cycle in which they are asserted. The
// pipeline registers sample them at the next rising edge.
//
// Ports:
//   clk            in   1      pipeline clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   hazard_id_exe  in   1      RAW hazard against the ID/EXE producer
//   hazard_exe_mem in   1      RAW hazard against the EXE/MEM producer
//   hazard_mem_wb  in   1      RAW hazard against the MEM/WB producer
//   branch_taken   in   1      redirect resolved in EXE this cycle
//   mem_wb_valid   in   1      MEM/WB holds a real instruction
//   mem_wb_rfwen   in   1      MEM/WB instruction writes the register file
//   mem_wb_pc      in   PC_W   PC of the MEM/WB instruction
//   pc_stall       out  1      hold the PC register
//   if_id_stall    out  1      hold the IF/ID register
//   if_id_flush    out  1      clear IF/ID to NOP
//   id_exe_bubble  out  1      load NOP into ID/EXE
//   last_wb_pc     out  PC_W   PC of the most recent register-writing write-back
//   stall_err      out  1      sticky watchdog error flag
//   stall_cnt      out  CNT_W  total stalled cycles, saturating
//   flush_cnt      out  CNT_W  total flush events, saturating
//   state          out  2      FSM state (0 RUN, 1 STALL, 2 FLUSH), for debug
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     MAX_STALL = 3,
  parameter int unsigned     CNT_W     = 32,
  parameter logic [PC_W-1:0] WB_PC_RST = PC_W'(32'hFFFF_FFFC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_id_exe,
  input  logic             hazard_exe_mem,
  input  logic             hazard_mem_wb,
  input  logic             branch_taken,
  input  logic             mem_wb_valid,
  input  logic             mem_wb_rfwen,
  input  logic [PC_W-1:0]  mem_wb_pc,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic [PC_W-1:0]  last_wb_pc,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  // run_len only has to count up to MAX_STALL, because it saturates there.
  localparam int unsigned     RL_W   = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);
  localparam logic [RL_W-1:0] RL_ONE = RL_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_BAD   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [RL_W-1:0] run_len_q, run_len_d;
  logic            stall_err_q, stall_err_d;
  logic [PC_W-1:0] last_wb_pc_q, last_wb_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hz;
  logic stall;
  logic flush;

  // A redirect beats a stall, because the instruction waiting in ID is on
  // the wrong path and is about to be squashed anyway.
  assign hz    = hazard_id_exe | hazard_exe_mem | hazard_mem_wb;
  assign flush = branch_taken;
  assign stall = hz & ~branch_taken;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (also holds run length and watchdog flag)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      run_len_q   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      stall_err_q <= stall_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    stall_err_d = stall_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d   = ST_STALL;
          run_len_d = RL_ONE;
        end else if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (stall) begin
          state_d = ST_STALL;
          // One more stall past MAX_STALL trips the watchdog. The counter
          // stays pinned, so a long run keeps the flag raised but does not wrap.
          if (run_len_q == RL_MAX) begin
            stall_err_d = 1'b1;
          end else begin
            run_len_d = run_len_q + RL_ONE;
          end
        end else if (flush) begin
          state_d   = ST_FLUSH;
          run_len_d = '0;
        end else begin
          state_d   = ST_RUN;
          run_len_d = '0;
        end
      end
      ST_FLUSH: begin
        if (stall) begin
          state_d   = ST_STALL;
          run_len_d = RL_ONE;
        end else if (flush) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // The encoding that should never occur goes back to RUN.
        state_d   = ST_RUN;
        run_len_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs. The pipeline controls are combinational and do
  // not depend on the state; the state is only exported for observation.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_stall      = stall;
    if_id_stall   = stall;
    if_id_flush   = flush;
    id_exe_bubble = stall | flush;
    state         = state_q;
    stall_err     = stall_err_q;
  end

  // ---------------------------------------------------------------------------
  // Last write-back PC and saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    last_wb_pc_d = last_wb_pc_q;
    if (mem_wb_valid && mem_wb_rfwen) begin
      last_wb_pc_d = mem_wb_pc;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wb_pc_q <= WB_PC_RST;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      last_wb_pc_q <= last_wb_pc_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign last_wb_pc = last_wb_pc_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. There are two instances. The main one
// uses the default parameters. A second one, with 3-bit counters, shares the
// same inputs so that counter saturation can be seen in a short run.
// Expected values come from a behavioural model. The model tracks the length
// of consecutive stall runs, the event totals and the last write-back PC as
// plain integers. A queue carries the expected registered state into the next
// check.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int unsigned MAX_STALL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  // ---------------- DUT signals ----------------
  logic        hazard_id_exe = 1'b0, hazard_exe_mem = 1'b0, hazard_mem_wb = 1'b0;
  logic        branch_taken = 1'b0, mem_wb_valid = 1'b0, mem_wb_rfwen = 1'b0;
  logic [31:0] mem_wb_pc = '0;
  logic        pc_stall, if_id_stall, if_id_flush, id_exe_bubble, stall_err;
  logic [31:0] last_wb_pc, stall_cnt, flush_cnt;
  logic [1:0]  state;

  logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_exe_bubble, s_stall_err;
  logic [31:0] s_last_wb_pc;
  logic [2:0]  s_stall_cnt, s_flush_cnt;
  logic [1:0]  s_state;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .hazard_id_exe(hazard_id_exe), .hazard_exe_mem(hazard_exe_mem),
    .hazard_mem_wb(hazard_mem_wb), .branch_taken(branch_taken),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rfwen(mem_wb_rfwen), .mem_wb_pc(mem_wb_pc),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_exe_bubble(id_exe_bubble), .last_wb_pc(last_wb_pc), .stall_err(stall_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  hazard_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .hazard_id_exe(hazard_id_exe), .hazard_exe_mem(hazard_exe_mem),
    .hazard_mem_wb(hazard_mem_wb), .branch_taken(branch_taken),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rfwen(mem_wb_rfwen), .mem_wb_pc(mem_wb_pc),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_exe_bubble(s_id_exe_bubble), .last_wb_pc(s_last_wb_pc), .stall_err(s_stall_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];          // {state, stall_err, last_wb_pc}

  int unsigned     m_run;         // consecutive stalled edges, unbounded
  logic            m_err;
  longint unsigned m_stalls, m_flushes;
  logic [31:0]     m_wb;
  logic            m_last_stall, m_last_flush;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] snap();
    logic [1:0] st;
    st = m_last_stall ? 2'd1 : (m_last_flush ? 2'd2 : 2'd0);
    return {st, m_err, m_wb};
  endfunction

  function automatic longint unsigned sat7(input longint unsigned v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    m_wb = 32'hFFFF_FFFC; m_last_stall = 1'b0; m_last_flush = 1'b0;
    exp_q.delete();
    exp_q.push_back(snap());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_zero();
    {hazard_id_exe, hazard_exe_mem, hazard_mem_wb, branch_taken} = 4'b0000;
    mem_wb_valid = 1'b0; mem_wb_rfwen = 1'b0; mem_wb_pc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_zero();
    #1;
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_last_wb_pc", {32'd0, last_wb_pc}, 64'hFFFF_FFFC);
    chk("rst_ctrl", {60'd0, pc_stall, if_id_stall, if_id_flush, id_exe_bubble}, 64'd0);
    chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    chk("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
    chk("rst_stall_err", {63'd0, stall_err}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One pipeline cycle. hb = {hazard_id_exe, hazard_exe_mem, hazard_mem_wb,
  // branch_taken}. Returns 1 time unit after the rising edge.
  task automatic cycle(input logic [3:0] hb, input logic v, input logic rfw,
                       input logic [31:0] pc);
    logic e_stall, e_flush;
    logic [34:0] s;
    @(negedge clk);
    {hazard_id_exe, hazard_exe_mem, hazard_mem_wb, branch_taken} = hb;
    mem_wb_valid = v; mem_wb_rfwen = rfw; mem_wb_pc = pc;
    #1;
    e_flush = hb[0];
    e_stall = (|hb[3:1]) & ~hb[0];
    chk("pc_stall", {63'd0, pc_stall}, {63'd0, e_stall});
    chk("if_id_stall", {63'd0, if_id_stall}, {63'd0, e_stall});
    chk("if_id_flush", {63'd0, if_id_flush}, {63'd0, e_flush});
    chk("id_exe_bubble", {63'd0, id_exe_bubble}, {63'd0, e_stall | e_flush});
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      s = exp_q.pop_front();
      chk("state", {62'd0, state}, {62'd0, s[34:33]});
      chk("stall_err", {63'd0, stall_err}, {63'd0, s[32]});
      chk("last_wb_pc", {32'd0, last_wb_pc}, {32'd0, s[31:0]});
    end
    chk("stall_cnt", {32'd0, stall_cnt}, m_stalls);
    chk("flush_cnt", {32'd0, flush_cnt}, m_flushes);
    chk("sat_stall_cnt", {61'd0, s_stall_cnt}, sat7(m_stalls));
    chk("sat_flush_cnt", {61'd0, s_flush_cnt}, sat7(m_flushes));
    @(posedge clk);
    if (e_stall) begin
      m_run++;
      m_stalls++;
      if (m_run > MAX_STALL) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
    if (e_flush) m_flushes++;
    if (v && rfw) m_wb = pc;
    m_last_stall = e_stall;
    m_last_flush = e_flush;
    exp_q.push_back(snap());
    #1;
  endtask

  task automatic idle();
    cycle(4'b0000, 1'b0, 1'b0, 32'd0);
  endtask

  // ---------------- combinational truth table ----------------
  typedef struct {
    logic [3:0] hb;
    logic       e_pcs;
    logic       e_fl;
    logic       e_bub;
  } vec_t;
  vec_t tbl[8];

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{4'b0100, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{4'b0010, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{4'b1110, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{4'b0101, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{4'b1111, 1'b0, 1'b1, 1'b1};

    drive_zero();
    do_reset();

    // Table vectors, separated by idles so that no stall run gets long.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].hb, 1'b0, 1'b0, 32'd0);
      chk("tbl_pc_stall", {63'd0, pc_stall}, {63'd0, tbl[i].e_pcs});
      chk("tbl_flush", {63'd0, if_id_flush}, {63'd0, tbl[i].e_fl});
      chk("tbl_bubble", {63'd0, id_exe_bubble}, {63'd0, tbl[i].e_bub});
      idle();
    end

    // Three-cycle stall, then a flush that arrives together with a hazard.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1000, 1'b0, 1'b0, 32'd0);
      chk("t2_pc_stall", {63'd0, pc_stall}, 64'd1);
      chk("t2_state", {62'd0, state}, 64'd1);
    end
    idle();
    chk("t2_state_back", {62'd0, state}, 64'd0);
    chk("t2_stall_cnt", {32'd0, stall_cnt}, 64'd3);
    chk("t2_stall_err", {63'd0, stall_err}, 64'd0);
    cycle(4'b0101, 1'b0, 1'b0, 32'd0);
    chk("t3_pc_stall", {63'd0, pc_stall}, 64'd0);
    chk("t3_flush", {63'd0, if_id_flush}, 64'd1);
    chk("t3_bubble", {63'd0, id_exe_bubble}, 64'd1);
    chk("t3_state", {62'd0, state}, 64'd2);
    chk("t3_flush_cnt", {32'd0, flush_cnt}, 64'd1);
    chk("t3_stall_cnt", {32'd0, stall_cnt}, 64'd3);
    idle();

    // Watchdog: the 4th consecutive stall edge trips it, and it stays sticky.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0010, 1'b0, 1'b0, 32'd0);
      chk("t4_err_step", {63'd0, stall_err}, (i == 3) ? 64'd1 : 64'd0);
    end
    idle();
    idle();
    chk("t4_err_sticky", {63'd0, stall_err}, 64'd1);
    do_reset();

    // Last write-back PC loads only when the instruction writes the register file.
    cycle(4'b0000, 1'b1, 1'b1, 32'h0000_0010);
    chk("t5_wb_first", {32'd0, last_wb_pc}, 64'h10);
    cycle(4'b0000, 1'b1, 1'b0, 32'h0000_0014);
    chk("t5_wb_hold", {32'd0, last_wb_pc}, 64'h10);
    idle();

    // Counter saturation, seen on the 3-bit instance.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0100, 1'b0, 1'b0, 32'd0);
      cycle(4'b0001, 1'b0, 1'b0, 32'd0);
    end
    idle();
    chk("t6_sat_stall", {61'd0, s_stall_cnt}, 64'd7);
    chk("t6_sat_flush", {61'd0, s_flush_cnt}, 64'd7);
    chk("t6_full_stall", {32'd0, stall_cnt}, 64'd10);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    cycle(4'b1000, 1'b0, 1'b0, 32'd0);
    cycle(4'b1000, 1'b0, 1'b0, 32'd0);
    chk("t6_pre_state", {62'd0, state}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_state", {62'd0, state}, 64'd0);
    chk("t6_async_run_len", {62'd0, dut.run_len_q}, 64'd0);
    chk("t6_async_pc_stall", {63'd0, pc_stall}, 64'd1);
    chk("t6_async_cnt", {32'd0, stall_cnt}, 64'd0);
    do_reset();

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] hb;
      hb[3] = ($urandom_range(0, 3) == 0);
      hb[2] = ($urandom_range(0, 4) == 0);
      hb[1] = ($urandom_range(0, 5) == 0);
      hb[0] = ($urandom_range(0, 5) == 0);
      cycle(hb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_FFFC);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
